// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and elaboration-time KMP transition function
package seq_det_pkg;

   localparam int MAX_N = 16;

   function automatic int state_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Next matched-prefix length from state k on bit b. The received string is
   // pattern[0..kk-1] followed by b (receive order); the result is the longest
   // pattern prefix that is also a suffix of it. Out-of-range states map to 0.
   function automatic int kmp_next(input logic [MAX_N-1:0] pattern, input int n,
                                   input int k, input logic b, input bit overlap);
      int   kk;
      int   res;
      int   j;
      bit   ok;
      logic s_c;
      res = 0;
      if (k > n) return 0;
      kk = (k == n && !overlap) ? 0 : k;
      for (int len = 1; len <= n; len++) begin
         if (len <= kk + 1) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++) begin
               j = kk + 1 - len + i;
               if (j == kk) s_c = b;
               else         s_c = pattern[n-1-j];
               if (s_c != pattern[n-1-i]) ok = 1'b0;
            end
            if (ok) res = len;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_det_if.sv
// rtl/seq_det_if.sv - serial bit stream in, match status out; det_count with SEQ_DET_COUNT_EN
interface seq_det_if
   import seq_det_pkg::*;
#(
   parameter int N = 3
`ifdef SEQ_DET_COUNT_EN
   , parameter int CNT_W = 8
`endif
);

   logic                  en;
   logic                  din;
   logic                  det;
   logic [state_w(N)-1:0] state_o;
`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0]      det_count;

   modport master (output en, output din, input det, input state_o, input det_count);
   modport slave  (input en, input din, output det, output state_o, output det_count);
`else
   modport master (output en, output din, input det, input state_o);
   modport slave  (input en, input din, output det, output state_o);
`endif

endinterface

// File: rtl/seq_det_next_state.sv
// rtl/seq_det_next_state.sv - combinational (state, din) -> next state from an elaborated table
module seq_det_next_state
   import seq_det_pkg::*;
#(
   parameter int             N       = 3,
   parameter logic [N-1:0]   PATTERN = 3'b101,
   parameter bit             OVERLAP = 1'b1,
   localparam int            SW      = state_w(N)
) (
   input  logic [SW-1:0] state_i,
   input  logic          din_i,
   output logic [SW-1:0] nxt_o
);

   localparam int               TAB_SZ  = 2 ** SW;
   localparam logic [MAX_N-1:0] PAT_EXT = MAX_N'(PATTERN);

   logic [SW-1:0] nxt0 [TAB_SZ];
   logic [SW-1:0] nxt1 [TAB_SZ];

   // Unreachable encodings above N resolve to state 0.
   for (genvar k = 0; k < TAB_SZ; k++) begin : g_tab
      localparam int T0 = kmp_next(PAT_EXT, N, k, 1'b0, OVERLAP);
      localparam int T1 = kmp_next(PAT_EXT, N, k, 1'b1, OVERLAP);
      assign nxt0[k] = SW'(T0);
      assign nxt1[k] = SW'(T1);
   end

   assign nxt_o = din_i ? nxt1[state_i] : nxt0[state_i];

endmodule

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - Moore serial pattern detector; optional match counter under SEQ_DET_COUNT_EN
module moore_seq_detector
   import seq_det_pkg::*;
#(
   parameter int           N       = 3,
   parameter logic [N-1:0] PATTERN = 3'b101,
   parameter bit           OVERLAP = 1'b1,
   parameter int           CNT_W   = 8
) (
   input  logic      clk,
   input  logic      rst,
   seq_det_if.slave  bus
);

   localparam int SW = state_w(N);

   if (N < 1 || N > MAX_N || CNT_W < 1) begin : g_param_chk
      $error("moore_seq_detector: N must be 1..16 and CNT_W at least 1");
   end

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   logic [SW-1:0] nxt;

   seq_det_next_state #(
      .N       (N),
      .PATTERN (PATTERN),
      .OVERLAP (OVERLAP)
   ) u_next (
      .state_i (state_q),
      .din_i   (bus.din),
      .nxt_o   (nxt)
   );

   always_comb begin
      state_d = state_q;
      if (bus.en) state_d = nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= '0;
      else     state_q <= state_d;
   end

   assign bus.state_o = state_q;
   assign bus.det     = (state_q == SW'(N));

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // An N->N step under overlap counts as a fresh match.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.en && state_d == SW'(N) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.det_count = cnt_q;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// tb/tb_moore_seq_detector.sv - directed vectors for three detector configurations; count checks with SEQ_DET_COUNT_EN
module tb_moore_seq_detector;
   import seq_det_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

`ifdef SEQ_DET_COUNT_EN
   seq_det_if #(.N(3), .CNT_W(8)) bus_a ();
   seq_det_if #(.N(3), .CNT_W(8)) bus_b ();
   seq_det_if #(.N(4), .CNT_W(2)) bus_c ();
`else
   seq_det_if #(.N(3)) bus_a ();
   seq_det_if #(.N(3)) bus_b ();
   seq_det_if #(.N(4)) bus_c ();
`endif

   moore_seq_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u_dut_a (
      .clk (clk), .rst (rst), .bus (bus_a));
   moore_seq_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_dut_b (
      .clk (clk), .rst (rst), .bus (bus_b));
   moore_seq_detector #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_dut_c (
      .clk (clk), .rst (rst), .bus (bus_c));

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // a: 101 overlap, b: 101 no overlap, c: 1111 overlap with a 2-bit counter
   task automatic step(input string tag, input logic r, input logic e, input logic d,
                       input int sa, input int sb, input int sc,
                       input int ca, input int cb, input int cc);
      @(negedge clk);
      rst = r;
      bus_a.en = e; bus_a.din = d;
      bus_b.en = e; bus_b.din = d;
      bus_c.en = e; bus_c.din = d;
      @(posedge clk);
      #1;
      chk({tag, "/a_state"}, int'(bus_a.state_o), sa);
      chk({tag, "/a_det"},   int'(bus_a.det), (sa == 3) ? 1 : 0);
      chk({tag, "/b_state"}, int'(bus_b.state_o), sb);
      chk({tag, "/b_det"},   int'(bus_b.det), (sb == 3) ? 1 : 0);
      chk({tag, "/c_state"}, int'(bus_c.state_o), sc);
      chk({tag, "/c_det"},   int'(bus_c.det), (sc == 4) ? 1 : 0);
`ifdef SEQ_DET_COUNT_EN
      chk({tag, "/a_cnt"}, int'(bus_a.det_count), ca);
      chk({tag, "/b_cnt"}, int'(bus_b.det_count), cb);
      chk({tag, "/c_cnt"}, int'(bus_c.det_count), cc);
`else
      if (ca < 0 || cb < 0 || cc < 0) $display("negative count expectation in %s", tag);
`endif
   endtask

   initial begin
      bus_a.en = 1'b0; bus_a.din = 1'b0;
      bus_b.en = 1'b0; bus_b.din = 1'b0;
      bus_c.en = 1'b0; bus_c.din = 1'b0;

      step("rst0", 1, 1, 1, 0, 0, 0, 0, 0, 0);
      step("rst1", 1, 1, 1, 0, 0, 0, 0, 0, 0);

      step("ov_b1", 0, 1, 1, 1, 1, 1, 0, 0, 0);
      step("ov_b2", 0, 1, 0, 2, 2, 0, 0, 0, 0);
      step("ov_b3", 0, 1, 1, 3, 3, 1, 1, 1, 0);
      step("ov_b4", 0, 1, 0, 2, 0, 0, 1, 1, 0);
      step("ov_b5", 0, 1, 1, 3, 1, 1, 2, 1, 0);

      step("rst2",  1, 1, 0, 0, 0, 0, 0, 0, 0);
      step("en_b1", 0, 1, 1, 1, 1, 1, 0, 0, 0);
      step("en_b2", 0, 1, 0, 2, 2, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         step("en_hold", 0, 0, logic'(i % 2 == 0), 2, 2, 0, 0, 0, 0);
      step("en_b3", 0, 1, 1, 3, 3, 1, 1, 1, 0);

      step("mid_b1", 0, 1, 1, 1, 1, 2, 1, 1, 0);
      step("mid_b2", 0, 1, 0, 2, 2, 0, 1, 1, 0);
      step("mid_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0);
      step("mid_b3", 0, 1, 1, 1, 1, 1, 0, 0, 0);

      step("rst_pri", 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step("ones1", 0, 1, 1, 1, 1, 1, 0, 0, 0);
      step("ones2", 0, 1, 1, 1, 1, 2, 0, 0, 0);
      step("ones3", 0, 1, 1, 1, 1, 3, 0, 0, 0);
      step("ones4", 0, 1, 1, 1, 1, 4, 0, 0, 1);
      step("ones5", 0, 1, 1, 1, 1, 4, 0, 0, 2);
      step("ones6", 0, 1, 1, 1, 1, 4, 0, 0, 3);
      step("ones7", 0, 1, 1, 1, 1, 4, 0, 0, 3);
      step("n_hold", 0, 0, 0, 1, 1, 4, 0, 0, 3);
      step("n_drop", 0, 1, 0, 2, 2, 0, 0, 0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
